// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants and ID/EX record types.
// Pure definitions, no logic; no latency or backpressure of its own.
package rv32_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        legal;
        alu_ctrl_e   alu_ctrl;
        a_sel_e      a_sel;
        b_sel_e      b_sel;
        logic [31:0] imm;
        logic        writes_rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
    } dec_t;

    typedef struct packed {
        logic        valid;
        alu_ctrl_e   alu_ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic [2:0]  funct3;
        logic        illegal;
    } ex_t;

endpackage

// File: rtl/alu_op_decode.sv
// Instruction word -> ALU code, operand selects, immediate and memory/branch flags.
// Combinational, zero latency; no backpressure (pure function of instr).
module alu_op_decode
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    alu_ctrl_e   f3_op;
    logic        f3_ok;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    // Shared by OP and OP-IMM; shifts and the unsigned compare fall out as illegal.
    always_comb begin
        f3_ok = 1'b1;
        f3_op = ALU_ADD;
        case (funct3)
            F3_ADD:  f3_op = ALU_ADD;
            F3_AND:  f3_op = ALU_AND;
            F3_OR:   f3_op = ALU_OR;
            F3_XOR:  f3_op = ALU_XOR;
            F3_SLT:  f3_op = ALU_SLT;
            default: f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec = '0;
        case (opcode)
            OPC_OP: begin
                dec.writes_rd = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec.legal    = f3_ok;
                    dec.alu_ctrl = f3_op;
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    dec.legal    = 1'b1;
                    dec.alu_ctrl = ALU_SUB;
                end
            end
            OPC_OPIMM: begin
                dec.legal     = f3_ok;
                dec.alu_ctrl  = f3_op;
                dec.b_sel     = B_IMM;
                dec.imm       = imm_i;
                dec.writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                dec.legal     = 1'b1;
                dec.b_sel     = B_IMM;
                dec.imm       = imm_i;
                dec.mem_rd    = 1'b1;
                dec.writes_rd = 1'b1;
            end
            OPC_STORE: begin
                dec.legal  = 1'b1;
                dec.b_sel  = B_IMM;
                dec.imm    = imm_s;
                dec.mem_wr = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE: begin
                        dec.legal    = 1'b1;
                        dec.alu_ctrl = ALU_SUB;
                    end
                    F3_BLT, F3_BGE: begin
                        dec.legal    = 1'b1;
                        dec.alu_ctrl = ALU_SLT;
                    end
                    default: dec.legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec.legal     = 1'b1;
                dec.a_sel     = A_ZERO;
                dec.b_sel     = B_IMM;
                dec.imm       = imm_u;
                dec.writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec.legal     = 1'b1;
                dec.a_sel     = A_PC;
                dec.b_sel     = B_IMM;
                dec.imm       = imm_u;
                dec.writes_rd = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue register: decodes one instruction and registers ALU operands/control.
// Latency 1 cycle; stall holds the register, flush (over stall) loads a bubble.
module id_ex_alu_issue
    import rv32_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_branch,
    output logic [2:0]      ex_funct3,
    output logic            ex_illegal
);

    dec_t dec;
    ex_t  ex_nxt;
    ex_t  ex_q;

    alu_op_decode u_dec (
        .instr (id_instr),
        .dec   (dec)
    );

    always_comb begin
        ex_nxt = '0;
        if (id_valid && dec.legal) begin
            ex_nxt.valid    = 1'b1;
            ex_nxt.alu_ctrl = dec.alu_ctrl;
            case (dec.a_sel)
                A_RS1:   ex_nxt.a = id_rs1_data;
                A_PC:    ex_nxt.a = id_pc;
                default: ex_nxt.a = '0;
            endcase
            ex_nxt.b          = (dec.b_sel == B_IMM) ? dec.imm : id_rs2_data;
            ex_nxt.store_data = dec.mem_wr ? id_rs2_data : '0;
            ex_nxt.rd         = dec.writes_rd ? id_instr[11:7] : 5'd0;
            // x0 is never written back, so suppress the write enable here.
            ex_nxt.reg_write  = dec.writes_rd && (id_instr[11:7] != 5'd0);
            ex_nxt.mem_rd     = dec.mem_rd;
            ex_nxt.mem_wr     = dec.mem_wr;
            ex_nxt.branch     = dec.branch;
            ex_nxt.funct3     = id_instr[14:12];
        end else if (id_valid && ILLEGAL_TRAP) begin
            ex_nxt.valid   = 1'b1;
            ex_nxt.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q <= ex_nxt;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_a          = ex_q.a;
    assign ex_b          = ex_q.b;
    assign ex_store_data = ex_q.store_data;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_rd     = ex_q.mem_rd;
    assign ex_mem_wr     = ex_q.mem_wr;
    assign ex_branch     = ex_q.branch;
    assign ex_funct3     = ex_q.funct3;
    assign ex_illegal    = ex_q.illegal;

endmodule
